// File: rtl/life_board_arbiter_if.sv
// Bus bundle between the board-RAM arbiter, its three requesters and the RAM macro.
// The arbiter takes the slave modport; the requester/RAM side takes the master modport.
interface life_board_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic              disp_rdata;

  logic              upd_req;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_gnt;
  logic              upd_rvalid;
  logic              upd_rdata;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_gnt;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              ram_rdata;

  logic              clear_status;
  logic              upd_starve;
  logic              wr_starve;

  modport slave (
    input  disp_req, disp_addr, upd_req, upd_addr, wr_req, wr_addr, wr_data,
           ram_rdata, clear_status,
    output disp_gnt, disp_rvalid, disp_rdata, upd_gnt, upd_rvalid, upd_rdata,
           wr_gnt, ram_en, ram_we, ram_addr, ram_wdata, upd_starve, wr_starve
  );

  modport master (
    output disp_req, disp_addr, upd_req, upd_addr, wr_req, wr_addr, wr_data,
           ram_rdata, clear_status,
    input  disp_gnt, disp_rvalid, disp_rdata, upd_gnt, upd_rvalid, upd_rdata,
           wr_gnt, ram_en, ram_we, ram_addr, ram_wdata, upd_starve, wr_starve
  );
endinterface

// File: rtl/life_board_arbiter.sv
// Single-port Game-of-Life board RAM arbiter: display has absolute priority,
// update-engine reads and init/copy writes share the remaining slots round-robin.
module life_board_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 15
) (
  input logic                 clk,
  input logic                 reset,
  life_board_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic              disp_gnt_c;
  logic              upd_gnt_c;
  logic              wr_gnt_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_wdata_c;

  logic              rr_ptr;
  logic              disp_rvalid_q;
  logic              upd_rvalid_q;
  logic [7:0]        upd_cnt;
  logic [7:0]        wr_cnt;
  logic              upd_starve_q;
  logic              wr_starve_q;

  logic              upd_wait;
  logic              wr_wait;

  // Grants are combinational so a requester can be served in the cycle it asks;
  // reset masks them so nothing reaches the RAM while reset is asserted.
  always_comb begin
    disp_gnt_c = 1'b0;
    upd_gnt_c  = 1'b0;
    wr_gnt_c   = 1'b0;
    if (!reset) begin
      if (bus.disp_req)
        disp_gnt_c = 1'b1;
      else if (bus.upd_req && (!bus.wr_req || !rr_ptr))
        upd_gnt_c = 1'b1;
      else if (bus.wr_req)
        wr_gnt_c = 1'b1;
    end
  end

  always_comb begin
    ram_addr_c  = '0;
    ram_wdata_c = 1'b0;
    if (disp_gnt_c) begin
      ram_addr_c = bus.disp_addr;
    end else if (upd_gnt_c) begin
      ram_addr_c = bus.upd_addr;
    end else if (wr_gnt_c) begin
      ram_addr_c  = bus.wr_addr;
      ram_wdata_c = bus.wr_data;
    end
  end

  assign upd_wait = bus.upd_req & ~upd_gnt_c;
  assign wr_wait  = bus.wr_req & ~wr_gnt_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= 1'b0;
      disp_rvalid_q <= 1'b0;
      upd_rvalid_q  <= 1'b0;
      upd_cnt       <= 8'd0;
      wr_cnt        <= 8'd0;
      upd_starve_q  <= 1'b0;
      wr_starve_q   <= 1'b0;
    end else begin
      if (upd_gnt_c)
        rr_ptr <= 1'b1;
      else if (wr_gnt_c)
        rr_ptr <= 1'b0;

      disp_rvalid_q <= disp_gnt_c;
      upd_rvalid_q  <= upd_gnt_c;

      if (!upd_wait)
        upd_cnt <= 8'd0;
      else if (upd_cnt != LIMIT)
        upd_cnt <= upd_cnt + 8'd1;

      if (!wr_wait)
        wr_cnt <= 8'd0;
      else if (wr_cnt != LIMIT)
        wr_cnt <= wr_cnt + 8'd1;

      // Flag sets on the edge the streak reaches the limit; a set beats a same-cycle clear.
      if (upd_wait && (upd_cnt >= LIMIT - 8'd1))
        upd_starve_q <= 1'b1;
      else if (bus.clear_status)
        upd_starve_q <= 1'b0;

      if (wr_wait && (wr_cnt >= LIMIT - 8'd1))
        wr_starve_q <= 1'b1;
      else if (bus.clear_status)
        wr_starve_q <= 1'b0;
    end
  end

  assign bus.disp_gnt    = disp_gnt_c;
  assign bus.upd_gnt     = upd_gnt_c;
  assign bus.wr_gnt      = wr_gnt_c;
  assign bus.ram_en      = disp_gnt_c | upd_gnt_c | wr_gnt_c;
  assign bus.ram_we      = wr_gnt_c;
  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_wdata   = ram_wdata_c;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.upd_rvalid  = upd_rvalid_q;
  assign bus.disp_rdata  = bus.ram_rdata;
  assign bus.upd_rdata   = bus.ram_rdata;
  assign bus.upd_starve  = upd_starve_q;
  assign bus.wr_starve   = wr_starve_q;

endmodule

// File: tb/tb_life_board_arbiter.sv
// Bench for life_board_arbiter: directed scenarios then random traffic against a
// reference model of the arbitration rules with a shadow copy of the board.
module tb_life_board_arbiter;
  localparam int AW  = 11;
  localparam int LIM = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  life_board_arbiter_if #(.ADDR_W(AW)) bus ();

  life_board_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  bit ram_mem[2**AW];
  bit shadow[2**AW];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  bit m_last_upd;
  bit m_dv, m_uv, m_drd, m_urd;
  int m_ustreak, m_wstreak;
  bit m_uflag, m_wflag;
  int m_uskip, m_wskip;

  // Observed values of the most recent cycle
  bit obs_dg, obs_ug, obs_wg, obs_we, obs_uv, obs_dv, obs_urd, obs_wst, obs_ust;
  bit ex_ug, ex_wg;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_upd = 1'b0;
    m_dv = 1'b0; m_uv = 1'b0; m_drd = 1'b0; m_urd = 1'b0;
    m_ustreak = 0; m_wstreak = 0;
    m_uflag = 1'b0; m_wflag = 1'b0;
    m_uskip = 0; m_wskip = 0;
  endtask

  // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input bit dr, input logic [AW-1:0] da,
                       input bit ur, input logic [AW-1:0] ua,
                       input bit wq, input logic [AW-1:0] wa, input bit wd,
                       input bit clr);
    bit eg_d, eg_u, eg_w, ewd;
    logic [AW-1:0] ea;
    bus.disp_req = dr; bus.disp_addr = da;
    bus.upd_req = ur;  bus.upd_addr = ua;
    bus.wr_req = wq;   bus.wr_addr = wa; bus.wr_data = wd;
    bus.clear_status = clr;
    #3;
    eg_d = dr; eg_u = 1'b0; eg_w = 1'b0;
    if (!dr) begin
      if (ur && wq) begin
        if (m_last_upd) eg_w = 1'b1;
        else            eg_u = 1'b1;
      end else if (ur) eg_u = 1'b1;
      else if (wq)     eg_w = 1'b1;
    end
    ea  = eg_d ? da : (eg_u ? ua : (eg_w ? wa : '0));
    ewd = eg_w ? wd : 1'b0;
    ex_ug = eg_u; ex_wg = eg_w;

    obs_dg = bus.disp_gnt; obs_ug = bus.upd_gnt; obs_wg = bus.wr_gnt; obs_we = bus.ram_we;
    obs_dv = bus.disp_rvalid; obs_uv = bus.upd_rvalid; obs_urd = bus.upd_rdata;
    obs_ust = bus.upd_starve; obs_wst = bus.wr_starve;

    chk_eq("disp_gnt", 32'(bus.disp_gnt), 32'(eg_d));
    chk_eq("upd_gnt", 32'(bus.upd_gnt), 32'(eg_u));
    chk_eq("wr_gnt", 32'(bus.wr_gnt), 32'(eg_w));
    chk_eq("one_gnt", 32'((32'(bus.disp_gnt) + 32'(bus.upd_gnt) + 32'(bus.wr_gnt)) <= 1), 32'd1);
    chk_eq("ram_en", 32'(bus.ram_en), 32'(eg_d | eg_u | eg_w));
    chk_eq("ram_we", 32'(bus.ram_we), 32'(eg_w));
    chk_eq("ram_addr", 32'(bus.ram_addr), 32'(ea));
    chk_eq("ram_wdata", 32'(bus.ram_wdata), 32'(ewd));
    chk_eq("disp_rvalid", 32'(bus.disp_rvalid), 32'(m_dv));
    chk_eq("upd_rvalid", 32'(bus.upd_rvalid), 32'(m_uv));
    if (m_dv) chk_eq("disp_rdata", 32'(bus.disp_rdata), 32'(m_drd));
    if (m_uv) chk_eq("upd_rdata", 32'(bus.upd_rdata), 32'(m_urd));
    chk_eq("upd_starve", 32'(bus.upd_starve), 32'(m_uflag));
    chk_eq("wr_starve", 32'(bus.wr_starve), 32'(m_wflag));

    // With display idle, a waiting requester may lose at most one slot to the other.
    if (!dr && ur && !bus.upd_gnt && bus.wr_gnt) m_uskip++;
    if (!dr && wq && !bus.wr_gnt && bus.upd_gnt) m_wskip++;
    if (!ur || bus.upd_gnt) m_uskip = 0;
    if (!wq || bus.wr_gnt)  m_wskip = 0;
    if (!dr && ur) chk_eq("upd_slots_lost", 32'(m_uskip <= 1), 32'd1);
    if (!dr && wq) chk_eq("wr_slots_lost", 32'(m_wskip <= 1), 32'd1);

    m_dv = eg_d; m_uv = eg_u;
    if (eg_d) m_drd = shadow[da];
    if (eg_u) m_urd = shadow[ua];
    if (eg_w) shadow[wa] = wd;
    if (eg_u)      m_last_upd = 1'b1;
    else if (eg_w) m_last_upd = 1'b0;
    if (ur && !eg_u) m_ustreak++; else m_ustreak = 0;
    if (wq && !eg_w) m_wstreak++; else m_wstreak = 0;
    if (m_ustreak >= LIM) m_uflag = 1'b1; else if (clr) m_uflag = 1'b0;
    if (m_wstreak >= LIM) m_wflag = 1'b1; else if (clr) m_wflag = 1'b0;
    @(posedge clk);
    #1;
  endtask

  bit pd, pu, pw, wdv, clr;
  logic [AW-1:0] ad, au, aw;

  initial begin
    model_reset();
    bus.disp_req = 1'b1; bus.disp_addr = 11'h003;
    bus.upd_req = 1'b1;  bus.upd_addr = 11'h004;
    bus.wr_req = 1'b1;   bus.wr_addr = 11'h005; bus.wr_data = 1'b1;
    bus.clear_status = 1'b0;

    // 1: everything requesting under reset, then release
    #12;
    chk_eq("t1_disp_gnt_rst", 32'(bus.disp_gnt), 32'd0);
    chk_eq("t1_upd_gnt_rst", 32'(bus.upd_gnt), 32'd0);
    chk_eq("t1_wr_gnt_rst", 32'(bus.wr_gnt), 32'd0);
    chk_eq("t1_ram_en_rst", 32'(bus.ram_en), 32'd0);
    chk_eq("t1_ram_we_rst", 32'(bus.ram_we), 32'd0);
    chk_eq("t1_rvalid_rst", 32'(bus.disp_rvalid | bus.upd_rvalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1, 11'h003, 1, 11'h004, 1, 11'h005, 1, 0);
    chk_eq("t1_disp_gnt", 32'(obs_dg), 32'd1);
    cycle(0, 11'h000, 0, 11'h000, 0, 11'h000, 0, 0);
    chk_eq("t1_disp_rvalid", 32'(obs_dv), 32'd1);

    // 2: upd and wr both requesting, display idle
    for (int i = 0; i < 6; i++) begin
      cycle(0, 11'h000, 1, 11'(16 + i), 1, 11'(32 + i), 1'(i), 0);
      chk_eq("t2_upd_gnt", 32'(obs_ug), 32'(i % 2 == 0));
      chk_eq("t2_ram_we", 32'(obs_we), 32'(i % 2 == 1));
    end

    // 3: write then immediate read of the same cell
    cycle(0, 11'h000, 0, 11'h000, 1, 11'h7FF, 1, 0);
    chk_eq("t3_wr_gnt", 32'(obs_wg), 32'd1);
    cycle(0, 11'h000, 1, 11'h7FF, 0, 11'h000, 0, 0);
    chk_eq("t3_upd_gnt", 32'(obs_ug), 32'd1);
    cycle(0, 11'h000, 0, 11'h000, 0, 11'h000, 0, 0);
    chk_eq("t3_upd_rvalid", 32'(obs_uv), 32'd1);
    chk_eq("t3_upd_rdata", 32'(obs_urd), 32'd1);

    // 4: display hogs the RAM while a write waits
    for (int i = 0; i < 20; i++) begin
      cycle(1, 11'(i), 0, 11'h000, 1, 11'h010, 1, (i == 16 || i == 17));
      chk_eq("t4_wr_gnt", 32'(obs_wg), 32'd0);
      chk_eq("t4_wr_starve", 32'(obs_wst), 32'(i >= 15));
    end
    cycle(0, 11'h000, 0, 11'h000, 1, 11'h010, 1, 0);
    chk_eq("t4_wr_gnt_late", 32'(obs_wg), 32'd1);
    cycle(0, 11'h000, 0, 11'h000, 0, 11'h000, 0, 1);
    chk_eq("t4_starve_held", 32'(obs_wst), 32'd1);
    cycle(0, 11'h000, 0, 11'h000, 0, 11'h000, 0, 0);
    chk_eq("t4_starve_cleared", 32'(obs_wst), 32'd0);

    // 5: reset pulse across the edge of an upd grant
    bus.disp_req = 1'b0; bus.wr_req = 1'b0;
    bus.upd_req = 1'b1; bus.upd_addr = 11'h005; bus.clear_status = 1'b0;
    #2;
    chk_eq("t5_upd_gnt_pre", 32'(bus.upd_gnt), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk_eq("t5_upd_gnt_rst", 32'(bus.upd_gnt), 32'd0);
    chk_eq("t5_ram_en_rst", 32'(bus.ram_en), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(0, 11'h000, 1, 11'h005, 1, 11'h009, 1, 0);
    chk_eq("t5_upd_rvalid", 32'(obs_uv), 32'd0);
    chk_eq("t5_rr_after_rst", 32'(obs_ug), 32'd1);

    // 6: random traffic with withdrawals and display bursts
    pd = 0; pu = 0; pw = 0; ad = '0; au = '0; aw = '0; wdv = 0;
    for (int c = 0; c < 10000; c++) begin
      if (pd) begin
        if ($urandom_range(0, 24) == 0) pd = 0;
      end else if ($urandom_range(0, 19) == 0) pd = 1;
      ad = 11'($urandom_range(0, 63));
      if (!pu) begin
        if ($urandom_range(0, 2) == 0) begin pu = 1; au = 11'($urandom_range(0, 63)); end
      end else if ($urandom_range(0, 29) == 0) pu = 0;
      if (!pw) begin
        if ($urandom_range(0, 2) == 0) begin
          pw = 1; aw = 11'($urandom_range(0, 63)); wdv = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 29) == 0) pw = 0;
      clr = ($urandom_range(0, 31) == 0);
      cycle(pd, ad, pu, au, pw, aw, wdv, clr);
      if (ex_ug) pu = 0;
      if (ex_wg) pw = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
